dac_spi_receiver: RTL and testbench
===================================

# dac_spi_receiver

Synthesizable SPI responder for the DAC serial link: the far end of the SPI_SCK / SPI_MOSI / DAC_CS interface driven by the DAC transmitter. It oversamples the SPI lines on CLK50MHZ and assembles 32-bit LTC2624-format command words MSB first. It decodes each word into command, address and data fields and echoes the previous word on SPI_MISO, as the DAC does. Used as an in-design bus monitor and as the loopback target for DAC driver verification.

## Interface
- SYNC_STAGES, 2, synchronizer flops on SPI_SCK, SPI_MOSI, DAC_CS (≥2)
- FRAME_BITS, 32, SCK rising edges per valid frame
- CLK50MHZ  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- SPI_SCK  in  1  serial clock from master, asynchronous to CLK50MHZ
- SPI_MOSI  in  1  serial data, valid at SCK rising edge
- DAC_CS  in  1  chip select, active low
- SPI_MISO  out  1  echo of previous valid word, MSB first, updates after SCK falling edge
- word_valid  out  1  one-cycle pulse: valid frame decoded
- frame_err  out  1  one-cycle pulse: frame closed with bit count ≠ FRAME_BITS
- cmd  out  4  word bits [23:20]
- addr  out  4  word bits [19:16]
- data  out  12  word bits [15:4]
- busy  out  1  high while in SHIFT

## Operation
- Inputs pass through SYNC_STAGES flops, then one edge-detect register: sck_rise, sck_fall, cs_fall, cs_rise are single-cycle strobes.
- FSM states: WAIT_IDLE, IDLE, SHIFT.
  - WAIT_IDLE (reset state): stay until synchronized DAC_CS = 1, then go to IDLE. A frame already in progress at reset release is never captured.
  - IDLE: on cs_fall, clear shift register and bit counter, load echo register into MISO shifter, go to SHIFT.
  - SHIFT: on sck_rise, shift_reg <= {shift_reg[30:0], mosi_s} and count increments, saturating at FRAME_BITS+1. On sck_fall, MISO shifter shifts left. On cs_rise, go to IDLE and close the frame.
- Frame close:
  - count == FRAME_BITS: latch cmd/addr/data from shift_reg, copy shift_reg to echo register, pulse word_valid.
  - Any other count, including 0 and overflow: pulse frame_err. cmd/addr/data and echo register keep their old values.
- SPI_MISO = MISO shifter bit 31. Shifts in 0. Forced 0 when not in SHIFT.
- Bits [31:24] and [3:0] are don't-care. They are not decoded but are stored in the echo.
- Simultaneous cs_rise and sck_rise in the same cycle: cs_rise wins and that SCK edge is not counted. cs_fall with sck_rise: the SCK edge is ignored.
- RST mid-frame: all state cleared, FSM returns to WAIT_IDLE, no pulses issued.

## Timing
- Reset values: SPI_MISO 0, word_valid 0, frame_err 0, cmd 0, addr 0, data 0, busy 0, echo register 0.
- Input-to-strobe latency: SYNC_STAGES+1 CLK50MHZ cycles.
- word_valid / frame_err assert SYNC_STAGES+2 cycles after the DAC_CS rising edge, for exactly 1 cycle. cmd/addr/data are valid in the same cycle and held until the next valid frame.
- SPI_MISO changes SYNC_STAGES+2 cycles after SCK falling edge. The first echo bit is present SYNC_STAGES+2 cycles after the DAC_CS falling edge.
- Input constraints:
  - SPI_SCK high and low times ≥ SYNC_STAGES+1 cycles.
  - DAC_CS setup/hold to SCK edges ≥ SYNC_STAGES+1 cycles.
  - Violations may miscount bits but must not hang the FSM.
- busy rises 1 cycle after cs_fall and falls 1 cycle after cs_rise.

## Test plan
- Reset, then 32-bit frame 0x00_3A_5C_30 at SCK = CLK/8 -> one word_valid pulse; cmd 0x3, addr 0xA, data 0x5C3; frame_err stays 0.
- Two back-to-back frames 0x00_3A_5C_30 then 0x00_2F_FFF0 -> MISO during the second frame reads 0x003A5C30 MSB first; second decode gives cmd 0x2, addr 0xF, data 0xFFF.
- Frame of 31 bits, then frame of 33 bits -> frame_err pulse each time, no word_valid; cmd/addr/data and echo unchanged from the last valid frame.
- RST asserted after bit 16 of a frame with DAC_CS still low -> all outputs return to reset values. Rest of that frame ignored (WAIT_IDLE), no pulse. Next full frame decodes normally.
- DAC_CS rises in the same synchronized cycle as the 32nd SCK rising edge -> count = 31, frame_err pulse.
- DAC_CS toggles with no SCK -> frame_err pulse; MISO 0 throughout.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// SPI responder for the DAC serial link: oversamples SCK/MOSI/CS on CLK50MHZ,
// assembles 32-bit LTC2624 command words MSB first and echoes the previous word on MISO.
module dac_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        DAC_CS,
  output logic        SPI_MISO,
  output logic        word_valid,
  output logic        frame_err,
  output logic [3:0]  cmd,
  output logic [3:0]  addr,
  output logic [11:0] data,
  output logic        busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  // Synchronizers reset to 0 so CS reads as asserted: a frame already in
  // progress when reset releases never produces a spurious cs_fall.
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic sck_s, mosi_s, cs_s;

  logic sck_prev_q, sck_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic sck_rise_q, sck_rise_d;
  logic sck_fall_q, sck_fall_d;
  logic cs_rise_q, cs_rise_d;
  logic cs_fall_q, cs_fall_d;
  logic mosi_bit_q, mosi_bit_d;

  state_t            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       miso_q, miso_d;
  logic [31:0]       echo_q, echo_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [3:0]        addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic              word_valid_q, word_valid_d;
  logic              frame_err_q, frame_err_d;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // Synchronizer chains and registered edge strobes. MOSI is delayed alongside
  // the strobes so the captured bit is the one present when SCK was seen rising.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], DAC_CS};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    sck_rise_d  = sck_s & ~sck_prev_q;
    sck_fall_d  = ~sck_s & sck_prev_q;
    cs_rise_d   = cs_s & ~cs_prev_q;
    cs_fall_d   = ~cs_s & cs_prev_q;
    mosi_bit_d  = mosi_s;
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    miso_d       = miso_q;
    echo_d       = echo_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    data_d       = data_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (cs_s) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        // An SCK edge coinciding with cs_fall is deliberately dropped.
        if (cs_fall_q) begin
          shift_d = '0;
          count_d = '0;
          miso_d  = echo_q;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise_q) begin
          state_d = IDLE;
          if (count_q == CNT_FULL) begin
            cmd_d        = shift_q[23:20];
            addr_d       = shift_q[19:16];
            data_d       = shift_q[15:4];
            echo_d       = shift_q;
            word_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end else begin
          if (sck_rise_q) begin
            shift_d = {shift_q[30:0], mosi_bit_q};
            if (count_q != CNT_SAT) begin
              count_d = count_q + 1'b1;
            end
          end
          if (sck_fall_q) begin
            miso_d = {miso_q[30:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sck_sync_q   <= '0;
      mosi_sync_q  <= '0;
      cs_sync_q    <= '0;
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b0;
      sck_rise_q   <= 1'b0;
      sck_fall_q   <= 1'b0;
      cs_rise_q    <= 1'b0;
      cs_fall_q    <= 1'b0;
      mosi_bit_q   <= 1'b0;
      state_q      <= WAIT_IDLE;
      shift_q      <= '0;
      count_q      <= '0;
      miso_q       <= '0;
      echo_q       <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_sync_q    <= cs_sync_d;
      sck_prev_q   <= sck_prev_d;
      cs_prev_q    <= cs_prev_d;
      sck_rise_q   <= sck_rise_d;
      sck_fall_q   <= sck_fall_d;
      cs_rise_q    <= cs_rise_d;
      cs_fall_q    <= cs_fall_d;
      mosi_bit_q   <= mosi_bit_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      miso_q       <= miso_d;
      echo_q       <= echo_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign SPI_MISO   = (state_q == SHIFT) & miso_q[31];
  assign busy       = (state_q == SHIFT);
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign cmd        = cmd_q;
  assign addr       = addr_q;
  assign data       = data_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Randomized frame bench for dac_spi_receiver: drives SPI frames at SCK well below
// CLK/8 and compares decode, pulses and the MISO echo against a word-level model.
module tb_dac_spi_receiver;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_mosi;
  logic        dac_cs;
  logic        spi_miso;
  logic        word_valid;
  logic        frame_err;
  logic [3:0]  cmd;
  logic [3:0]  addr;
  logic [11:0] data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Word-level reference: last accepted word and its decoded fields.
  logic [31:0] model_echo = '0;
  logic [31:0] exp_q[$];

  dac_spi_receiver #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
    .CLK50MHZ  (clk),
    .RST       (rst),
    .SPI_SCK   (spi_sck),
    .SPI_MOSI  (spi_mosi),
    .DAC_CS    (dac_cs),
    .SPI_MISO  (spi_miso),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .cmd       (cmd),
    .addr      (addr),
    .data      (data),
    .busy      (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
    check({tag, "_wv"},   {31'd0, word_valid}, 32'd0);
    check({tag, "_fe"},   {31'd0, frame_err}, 32'd0);
    check({tag, "_cmd"},  {28'd0, cmd}, 32'd0);
    check({tag, "_addr"}, {28'd0, addr}, 32'd0);
    check({tag, "_data"}, {20'd0, data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Drives one frame of nbits SCK pulses. cs_with_last raises CS together with
  // the final SCK rise; rst_after >= 0 pulses RST before that bit index.
  task automatic run_frame(input logic [31:0] word, input int nbits,
                           input bit cs_with_last, input int rst_after);
    bit          rst_done = 1'b0;
    int          counted;
    int          wv_cnt = 0;
    int          fe_cnt = 0;
    int          wv_at = 0;
    int          fe_at = 0;
    bit          exp_valid;
    logic [31:0] echo_at_start;
    logic [31:0] w;
    echo_at_start = model_echo;
    dac_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_rst");
        rst = 1'b0;
        rst_done = 1'b1;
        model_echo = '0;
        echo_at_start = '0;
      end
      spi_mosi = (i < 32) ? word[31-i] : 1'($urandom_range(0, 1));
      repeat (6) @(negedge clk);
      if (rst_done)
        check("miso_bit", {31'd0, spi_miso}, 32'd0);
      else
        check("miso_bit", {31'd0, spi_miso}, (i < 32) ? {31'd0, echo_at_start[31-i]} : 32'd0);
      check("busy_in_frame", {31'd0, busy}, {31'd0, !rst_done});
      if (cs_with_last && i == nbits - 1) break;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    if (!(cs_with_last && nbits > 0)) begin
      repeat (6) @(negedge clk);
      if (!rst_done && nbits < 32)
        check("miso_before_cs", {31'd0, spi_miso}, {31'd0, echo_at_start[31-nbits]});
      else
        check("miso_before_cs", {31'd0, spi_miso}, 32'd0);
    end
    dac_cs = 1'b1;
    if (cs_with_last && nbits > 0) spi_sck = 1'b1;

    counted   = (cs_with_last && nbits > 0) ? nbits - 1 : nbits;
    exp_valid = !rst_done && (counted == 32);
    if (exp_valid) begin
      exp_q.push_back(word);
      model_echo = word;
    end

    // Scoreboard window: observe pulses for 12 cycles after CS rises.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (word_valid) begin
        wv_cnt++;
        wv_at = k;
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("dec_cmd",  {28'd0, cmd},  {28'd0, w[23:20]});
          check("dec_addr", {28'd0, addr}, {28'd0, w[19:16]});
          check("dec_data", {20'd0, data}, {20'd0, w[15:4]});
        end else begin
          check("unexpected_word_valid", 32'd1, 32'd0);
        end
      end
      if (frame_err) begin
        fe_cnt++;
        fe_at = k;
      end
      if (k == 4) spi_sck = 1'b0;
    end
    check("word_valid_count", wv_cnt, {31'd0, exp_valid});
    check("frame_err_count", fe_cnt, {31'd0, !rst_done && !exp_valid});
    if (exp_valid) check("word_valid_latency", wv_at, 32'd4);
    if (!rst_done && !exp_valid) check("frame_err_latency", fe_at, 32'd4);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("miso_after", {31'd0, spi_miso}, 32'd0);
    check("hold_cmd",  {28'd0, cmd},  {28'd0, model_echo[23:20]});
    check("hold_addr", {28'd0, addr}, {28'd0, model_echo[19:16]});
    check("hold_data", {20'd0, data}, {20'd0, model_echo[15:4]});
  endtask

  initial begin
    int nb;
    bit cwl;
    rst = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    dac_cs = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    run_frame(32'h003A5C30, 32, 1'b0, -1);
    run_frame(32'h002FFFF0, 32, 1'b0, -1);
    run_frame($urandom, 31, 1'b0, -1);
    run_frame($urandom, 33, 1'b0, -1);
    run_frame(32'h12345678, 32, 1'b0, 16);
    run_frame(32'h003A5C30, 32, 1'b0, -1);
    run_frame(32'h00F1ABC0, 32, 1'b1, -1);
    run_frame(32'h0, 0, 1'b0, -1);

    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: nb = 32;
        3:       nb = 31;
        4:       nb = 33;
        default: nb = int'($urandom_range(0, 40));
      endcase
      cwl = (nb > 0) && ($urandom_range(0, 3) == 0);
      run_frame($urandom, nb, cwl, -1);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
